// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: shared encodings and scoreboard entry type for the hazard controller
package hazard_ctrl_unit_pkg;
  localparam int RD_W = 5;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_ALU = 2'd1, OP_LOAD = 2'd2, OP_STORE = 2'd3} optype_e;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_EX = 2'd1, FWD_MEM_ALU = 2'd2, FWD_MEM_LD = 2'd3} fwd_e;
  typedef struct packed {
    optype_e         optype;
    logic [RD_W-1:0] rd;
    logic            st_fwd;
  } sb_entry_t;
  // only ALU results and load data are ever written back, so only they can be forwarded
  function automatic logic produces(optype_e op);
    return op == OP_ALU || op == OP_LOAD;
  endfunction
  // EX result is the youngest value, so it wins over anything still in MEM
  function automatic fwd_e fwd_sel(logic hit_ex, optype_e ex_op, logic hit_mem, optype_e mem_op);
    return (hit_ex && ex_op == OP_ALU)    ? FWD_EX :
           (hit_mem && mem_op == OP_ALU)  ? FWD_MEM_ALU :
           (hit_mem && mem_op == OP_LOAD) ? FWD_MEM_LD : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one pipeline-stage scoreboard register with source-operand match logic
module hazard_sb_entry
  import hazard_ctrl_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  sb_entry_t       entry_d_i,
  input  logic            rs1use_i,
  input  logic [RD_W-1:0] rs1_i,
  input  logic            rs2use_i,
  input  logic [RD_W-1:0] rs2_i,
  output sb_entry_t       entry_q_o,
  output logic            hit1_o,
  output logic            hit2_o
);
  sb_entry_t entry_q;
  logic      live;
  assign entry_q_o = entry_q;
  assign live      = entry_q.rd != '0 && produces(entry_q.optype);
  assign hit1_o    = rs1use_i && live && rs1_i == entry_q.rd;
  assign hit2_o    = rs2use_i && live && rs2_i == entry_q.rd;
  // capture the instruction advancing into this stage, or a bubble when cleared
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) entry_q <= '0;
    else       entry_q <= clr_i ? '0 : entry_d_i;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: ID-stage forwarding, load-use stall and flush control for the 5-stage core
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W = RD_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic [REG_W-1:0] rd_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic             Branch_ID,
  input  logic             trap_redirect,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             rs2_fwd_MEM,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic             reg_EM_flush
);
  sb_entry_t ex_q, mem_q, ex_d;
  logic      h1_ex, h2_ex, h1_mem, h2_mem;
  logic      is_store, ex_load, stall;
  assign is_store = hazard_optype_ID == OP_STORE;
  assign ex_load  = ex_q.optype == OP_LOAD;
  // a store only needs the loaded value as data in MEM, where WB load data can be substituted
  assign stall    = ex_load && (h1_ex || (h2_ex && !is_store));
  assign ex_d     = '{optype: optype_e'(hazard_optype_ID), rd: rd_ID, st_fwd: is_store && h2_ex && ex_load};
  hazard_sb_entry u_ex (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (stall || trap_redirect),
    .entry_d_i (ex_d),
    .rs1use_i  (rs1use_ID),
    .rs1_i     (rs1_ID),
    .rs2use_i  (rs2use_ID),
    .rs2_i     (rs2_ID),
    .entry_q_o (ex_q),
    .hit1_o    (h1_ex),
    .hit2_o    (h2_ex)
  );
  hazard_sb_entry u_mem (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (trap_redirect),
    .entry_d_i (ex_q),
    .rs1use_i  (rs1use_ID),
    .rs1_i     (rs1_ID),
    .rs2use_i  (rs2use_ID),
    .rs2_i     (rs2_ID),
    .entry_q_o (mem_q),
    .hit1_o    (h1_mem),
    .hit2_o    (h2_mem)
  );
  assign forward_ctrl_A = fwd_sel(h1_ex, ex_q.optype, h1_mem, mem_q.optype);
  assign forward_ctrl_B = fwd_sel(h2_ex, ex_q.optype, h2_mem, mem_q.optype);
  assign rs2_fwd_MEM    = mem_q.st_fwd;
  assign PC_EN_IF       = !stall;
  assign reg_FD_EN      = !stall;
  // branch operands are not valid during a stall, so the redirect waits a cycle
  assign reg_FD_flush   = (Branch_ID && !stall) || trap_redirect;
  assign reg_DE_flush   = stall || trap_redirect;
  assign reg_EM_flush   = trap_redirect;
endmodule
